// File: rtl/ram.sv
// ram: single-port RAM, 2**ADDR_WIDTH words of DATA_WIDTH bits, one clock.
// Writes are synchronous. Reads return data only during an enabled read
// (cen=1, wen=0); in every other case S_dout is zero.
// Optional macro RAM_OUT_REG_EN: when defined, S_dout is registered, so read
// latency is one cycle. When it is undefined, the read path is combinational.
module ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] S_addr,
  input  logic [DATA_WIDTH-1:0] S_din,
  output logic [DATA_WIDTH-1:0] S_dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  // Decode the access type and fetch the addressed word.
  always_comb begin
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    rd_word_s = mem_r[S_addr];
    if (cen == 1'b1) begin
      if (wen == 1'b1) begin
        wr_en_s = 1'b1;
      end else begin
        rd_en_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
  end

  // Storage: reset clears every word at once and takes priority over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[S_addr] <= S_din;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout_r;

  // Registered read port. A word written on the previous edge is already in mem_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r <= '0;
    end else if (rd_en_s) begin
      dout_r <= rd_word_s;
    end else begin
      dout_r <= '0;
    end
  end

  assign S_dout = dout_r;
`else
  logic [DATA_WIDTH-1:0] dout_s;

  // Combinational read port. It is masked during reset so that a partly
  // cleared memory is never visible.
  always_comb begin
    dout_s = '0;
    if (rd_en_s && !reset) begin
      dout_s = rd_word_s;
    end else begin
      dout_s = '0;
    end
  end

  assign S_dout = dout_s;
`endif

endmodule

// File: tb/tb_ram.sv
// tb_ram: scoreboard bench for ram.
// Stimulus pushes one expected S_dout value per cycle from an array model.
// A monitor pops these values at the falling edge and compares them with the
// DUT output, lagging by one cycle when RAM_OUT_REG_EN is defined.
module tb_ram;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RAM_OUT_REG_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cen = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] S_addr = '0;
  logic [DW-1:0] S_din = '0;
  logic [DW-1:0] S_dout;

  logic [DW-1:0] model_mem [32];
  logic [DW-1:0] exp_q [$];
  int            cyc_q [$];
  int            cycle_no = 0;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .cen    (cen),
    .wen    (wen),
    .S_addr (S_addr),
    .S_din  (S_din),
    .S_dout (S_dout)
  );

  always #5 clk = ~clk;

  // One access cycle: apply the inputs, predict the output from the model,
  // update the model, then advance to just after the next rising edge.
  task automatic cyc(input logic r, input logic c, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    reset  = r;
    cen    = c;
    wen    = w;
    S_addr = a;
    S_din  = d;
    e = (!r && c && !w) ? model_mem[a] : 32'h0;
    exp_q.push_back(e);
    cyc_q.push_back(cycle_no);
    if (r) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    end else if (c && w) begin
      model_mem[a] = d;
    end
    cycle_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT output against the oldest expected value.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    int            n;
    if (exp_q.size() > LAG) begin
      e = exp_q.pop_front();
      n = cyc_q.pop_front();
      total_cnt++;
      if (S_dout === e) begin
        pass_cnt++;
      end else begin
        $display("FAIL dout cycle %0d: got %h expected %h", n, S_dout, e);
      end
    end
  end

  initial begin
    int wait_cnt;
    logic [AW-1:0] ra;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'hx;
    @(posedge clk);
    #1;
    // 1: reset, then read addresses 0, 2 and 31
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd31, 32'h0);
    // 2: write blocked by cen=0
    cyc(1'b0, 1'b0, 1'b1, 5'd2, 32'h7);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 32'h0);
    // 3: write addr 3, read 2 and 3
    cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'h5);
    cyc(1'b0, 1'b1, 1'b0, 5'd2, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
    // 4: boundary words and data patterns
    cyc(1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b1, 1'b1, 5'd0, 32'hA5A5_A5A5);
    cyc(1'b0, 1'b1, 1'b0, 5'd31, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
    // 6: cen=0 with non-zero data at a written address
    cyc(1'b0, 1'b0, 1'b0, 5'd31, 32'h1234_5678);
    // 5: reset overrides a simultaneous write
    cyc(1'b1, 1'b1, 1'b1, 5'd4, 32'h9);
    cyc(1'b0, 1'b1, 1'b0, 5'd4, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 5'd3, 32'h0);
    // read-after-write back to back, then random traffic
    cyc(1'b0, 1'b1, 1'b1, 5'd17, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 1'b0, 5'd17, 32'h0);
    for (int k = 0; k < 400; k++) begin
      ra = AW'($urandom_range(0, 31));
      cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
          $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
          ra, $urandom());
    end
    // flush with idle cycles
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    wait_cnt = 0;
    while (exp_q.size() > LAG && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > LAG) begin
      total_cnt++;
      $display("FAIL drain: %0d entries left, expected %0d", exp_q.size(), LAG);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
